control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the datapath's enable, output-select and ALU-op lines.
- Steps through the fetch (T0–T2) and execute (T3–T6) control sequence for each instruction.
- Sits beside the datapath: it reads the IR contents and the memory-ready strobe, and emits the control signals the datapath samples on the rising edge.

Parameters:
- OPC_W, 5, opcode field width (IR[31:27])
- NREG, 16, general registers; width of one-hot rIn/rOut vectors
- REG_W, 4, register-field width (Ra IR[26:23], Rb IR[22:19], Rc IR[18:15])

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-high reset
- run  in  1  start/continue fetching
- mem_rdy  in  1  memory read data valid on MDR input
- ir  in  32  current IR register contents
- rIn  out  NREG  one-hot register load enables
- rOut  out  NREG  one-hot register bus drivers
- HIIn, LOIn, PCIn, IRIn, MARIn, MDRIn  out  1 each  load enables
- Y_en, Z_en, Zlow_en, Zhigh_en  out  1 each  Y/Z register controls
- PCOut, MDROut, PCinc_en, MDRread  out  1 each
- opcode  out  OPC_W  ALU operation
- tstate  out  3  current step (0–6; 7 = IDLE/FAULT)
- done  out  1  one-cycle pulse in an instruction's last step
- illegal  out  1  sticky unsupported-opcode flag

Behaviour:
- Reset: async on clr=1. State goes to IDLE, illegal=0, all outputs 0, tstate=7.
- Outputs: Moore decode of the registered state plus the ir fields. Only signals listed for a state are 1; all others are 0.
- States:
  - IDLE: if run=1, go to T0.
  - T0: PCOut, MARIn, PCinc_en, Z_en. Go to T1.
  - T1: Zlow_en, PCIn, MDRread, MDRIn. Hold T1 while mem_rdy=0, keeping the same outputs. PCIn is asserted only in the cycle mem_rdy=1. Advance to T2 on mem_rdy=1.
  - T2: MDROut, IRIn. Go to T3.
  - T3:
    - 3-operand ops: rOut[Rb], Y_en.
    - mul/div: rOut[Ra], Y_en.
    - neg/not: rOut[Rb], opcode=ir op, Z_en, then go to T5.
    - Illegal opcode: go to FAULT with no outputs asserted.
  - T4: rOut[Rc] (rOut[Rb] for mul/div), opcode=ir op, Z_en.
  - T5:
    - Zlow_en plus rIn[Ra]; for mul/div, LOIn instead of rIn.
    - Non-mul/div: done=1, then go to T0 if run=1, else IDLE.
  - T6 (mul/div only): Zhigh_en, HIIn, done=1, then go to T0 if run=1, else IDLE.
  - FAULT: illegal=1, all other outputs 0. Held until clr.
- Legal opcodes: add 00101, sub 00110, and 00111, or 01000, shr 01001, shl 01011, ror 01100, rol 01101, mul 10001, div 10010, neg 10011, not 10100. All others are illegal.
- opcode output is 00000 in every state except the ALU-op steps (T4; T3 for neg/not).
- IR decode is performed only in T3 and later; ir is ignored during T0–T2.
- Register one-hot: bit index = field value; exactly one bit set when asserted.
- run deasserted mid-instruction: the current instruction completes.
- clr mid-instruction: immediate return to IDLE; no partial register write occurs after reset.

Optional Feature:
- Macro: CU_INSTR_COUNT_EN.
- When defined:
  - Adds output instr_count[31:0], cleared by clr.
  - Increments by 1 on each done pulse and wraps from 0xFFFFFFFF to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- add R1,R2,R3: ir=0x28918000, run=1, mem_rdy=1 -> T0..T5 in 6 cycles; T3 rOut=0x0004; T4 rOut=0x0008, opcode=00101; T5 rIn=0x0002; done at T5.
- mul R5,R7: ir=0x8AB80000 -> T3 rOut=0x0020; T4 rOut=0x0080, opcode=10001; T5 LOIn; T6 HIIn, Zhigh_en, done. 7 cycles total.
- neg R1,R2: ir=0x98900000 -> T3 rOut=0x0004, opcode=10011, Z_en; next state T5 with rIn=0x0002; T4 skipped.
- mem_rdy held 0 for 3 cycles in T1 -> tstate stays 1 for 4 cycles; MDRread stays 1; PCIn high only in the last cycle; then T2.
- ir opcode 11111 at T3 -> illegal=1 next cycle; all controls 0; state remains FAULT until clr pulse, then IDLE with illegal=0.
- clr asserted mid-T4 -> all outputs 0 asynchronously, tstate=7. With CU_INSTR_COUNT_EN: after 3 completed adds, instr_count=3.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) and execute (T3-T6) steps driving datapath controls.
// Optional macro CU_INSTR_COUNT_EN adds a wrapping count of completed instructions (instr_count).
module control_sequencer #(
  parameter int OPC_W = 5,
  parameter int NREG  = 16,
  parameter int REG_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_rdy,
  input  logic [31:0]      ir,
  output logic [NREG-1:0]  rIn,
  output logic [NREG-1:0]  rOut,
  output logic             HIIn,
  output logic             LOIn,
  output logic             PCIn,
  output logic             IRIn,
  output logic             MARIn,
  output logic             MDRIn,
  output logic             Y_en,
  output logic             Z_en,
  output logic             Zlow_en,
  output logic             Zhigh_en,
  output logic             PCOut,
  output logic             MDROut,
  output logic             PCinc_en,
  output logic             MDRread,
  output logic [OPC_W-1:0] opcode,
  output logic [2:0]       tstate,
  output logic             done,
  output logic             illegal
`ifdef CU_INSTR_COUNT_EN
  ,
  output logic [31:0]      instr_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FAULT
  } state_t;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00110;
  localparam logic [OPC_W-1:0] OP_AND = 5'b00111;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHL = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ROR = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ROL = 5'b01101;
  localparam logic [OPC_W-1:0] OP_MUL = 5'b10001;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NEG = 5'b10011;
  localparam logic [OPC_W-1:0] OP_NOT = 5'b10100;

  localparam int RA_MSB = 31 - OPC_W;
  localparam int RB_MSB = RA_MSB - REG_W;
  localparam int RC_MSB = RB_MSB - REG_W;

  state_t state_q, state_d;

  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] ra, rb, rc;
  logic [NREG-1:0]  ra_hot, rb_hot, rc_hot;
  logic             is_three, is_muldiv, is_unary;
  logic             unused_ir_bits;

  assign opc = ir[31 -: OPC_W];
  assign ra  = ir[RA_MSB -: REG_W];
  assign rb  = ir[RB_MSB -: REG_W];
  assign rc  = ir[RC_MSB -: REG_W];
  assign unused_ir_bits = ^ir[RC_MSB-REG_W:0];

  assign is_three  = opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
  assign is_muldiv = opc inside {OP_MUL, OP_DIV};
  assign is_unary  = opc inside {OP_NEG, OP_NOT};

  for (genvar gi = 0; gi < NREG; gi++) begin : g_hot
    assign ra_hot[gi] = (ra == REG_W'(gi));
    assign rb_hot[gi] = (rb == REG_W'(gi));
    assign rc_hot[gi] = (rc == REG_W'(gi));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rIn      = '0;
    rOut     = '0;
    HIIn     = 1'b0;
    LOIn     = 1'b0;
    PCIn     = 1'b0;
    IRIn     = 1'b0;
    MARIn    = 1'b0;
    MDRIn    = 1'b0;
    Y_en     = 1'b0;
    Z_en     = 1'b0;
    Zlow_en  = 1'b0;
    Zhigh_en = 1'b0;
    PCOut    = 1'b0;
    MDROut   = 1'b0;
    PCinc_en = 1'b0;
    MDRread  = 1'b0;
    opcode   = '0;
    tstate   = 3'd7;
    done     = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        tstate   = 3'd0;
        PCOut    = 1'b1;
        MARIn    = 1'b1;
        PCinc_en = 1'b1;
        Z_en     = 1'b1;
        state_d  = S_T1;
      end
      S_T1: begin
        // Wait here for memory; PC is only reloaded on the cycle the read completes.
        tstate  = 3'd1;
        Zlow_en = 1'b1;
        MDRread = 1'b1;
        MDRIn   = 1'b1;
        PCIn    = mem_rdy;
        if (mem_rdy) state_d = S_T2;
      end
      S_T2: begin
        tstate  = 3'd2;
        MDROut  = 1'b1;
        IRIn    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        tstate = 3'd3;
        if (is_three) begin
          rOut    = rb_hot;
          Y_en    = 1'b1;
          state_d = S_T4;
        end else if (is_muldiv) begin
          rOut    = ra_hot;
          Y_en    = 1'b1;
          state_d = S_T4;
        end else if (is_unary) begin
          rOut    = rb_hot;
          opcode  = opc;
          Z_en    = 1'b1;
          state_d = S_T5;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_T4: begin
        tstate  = 3'd4;
        rOut    = is_muldiv ? rb_hot : rc_hot;
        opcode  = opc;
        Z_en    = 1'b1;
        state_d = S_T5;
      end
      S_T5: begin
        tstate  = 3'd5;
        Zlow_en = 1'b1;
        if (is_muldiv) begin
          LOIn    = 1'b1;
          state_d = S_T6;
        end else begin
          rIn     = ra_hot;
          done    = 1'b1;
          state_d = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        tstate   = 3'd6;
        Zhigh_en = 1'b1;
        HIIn     = 1'b1;
        done     = 1'b1;
        state_d  = run ? S_T0 : S_IDLE;
      end
      S_FAULT: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef CU_INSTR_COUNT_EN
  logic [31:0] count_q, count_d;

  assign count_d = done ? count_q + 32'd1 : count_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end

  assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes the expected control word for each cycle,
// a monitor pops and compares at every falling clock edge and on each asynchronous clear.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic        hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in;
    logic        y_en, z_en, zlow_en, zhigh_en;
    logic        pc_out, mdr_out, pcinc_en, mdr_read;
    logic [4:0]  opc;
    logic [2:0]  ts;
    logic        done, illegal;
    logic [31:0] cnt;
  } ctl_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [31:0] ir = '0;

  logic [15:0] rIn, rOut;
  logic        HIIn, LOIn, PCIn, IRIn, MARIn, MDRIn;
  logic        Y_en, Z_en, Zlow_en, Zhigh_en;
  logic        PCOut, MDROut, PCinc_en, MDRread;
  logic [4:0]  opcode;
  logic [2:0]  tstate;
  logic        done, illegal;
`ifdef CU_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  control_sequencer #(.OPC_W(5), .NREG(16), .REG_W(4)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .rIn(rIn), .rOut(rOut),
    .HIIn(HIIn), .LOIn(LOIn), .PCIn(PCIn), .IRIn(IRIn), .MARIn(MARIn), .MDRIn(MDRIn),
    .Y_en(Y_en), .Z_en(Z_en), .Zlow_en(Zlow_en), .Zhigh_en(Zhigh_en),
    .PCOut(PCOut), .MDROut(MDROut), .PCinc_en(PCinc_en), .MDRread(MDRread),
    .opcode(opcode), .tstate(tstate), .done(done), .illegal(illegal)
`ifdef CU_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  ctl_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_count = 0;

  function automatic ctl_t sample();
    ctl_t a;
    a.r_in = rIn;       a.r_out = rOut;
    a.hi_in = HIIn;     a.lo_in = LOIn;     a.pc_in = PCIn;     a.ir_in = IRIn;
    a.mar_in = MARIn;   a.mdr_in = MDRIn;   a.y_en = Y_en;      a.z_en = Z_en;
    a.zlow_en = Zlow_en; a.zhigh_en = Zhigh_en; a.pc_out = PCOut; a.mdr_out = MDROut;
    a.pcinc_en = PCinc_en; a.mdr_read = MDRread;
    a.opc = opcode;     a.ts = tstate;      a.done = done;      a.illegal = illegal;
`ifdef CU_INSTR_COUNT_EN
    a.cnt = instr_count;
`else
    a.cnt = '0;
`endif
    return a;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk or posedge clr);
      #1;
      if (exp_q.size() > 0) begin
        ctl_t e, a;
        e = exp_q.pop_front();
        a = sample();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ctrl t=%0t tstate got=%0d want=%0d word got=%h want=%h",
                   $time, a.ts, e.ts, a, e);
        end
      end
    end
  end

  function automatic ctl_t blank(input int ts);
    ctl_t v;
    v = '0;
    v.ts = 3'(ts);
    return v;
  endfunction

  function automatic logic [15:0] hot(input logic [3:0] i);
    return 16'd1 << i;
  endfunction

  // 0 = illegal, 1 = three-operand, 2 = mul/div, 3 = neg/not
  function automatic int classify(input logic [4:0] op);
    case (op)
      5'b00101, 5'b00110, 5'b00111, 5'b01000,
      5'b01001, 5'b01011, 5'b01100, 5'b01101: return 1;
      5'b10001, 5'b10010:                      return 2;
      5'b10011, 5'b10100:                      return 3;
      default:                                 return 0;
    endcase
  endfunction

  task automatic push(input ctl_t v);
`ifdef CU_INSTR_COUNT_EN
    v.cnt = 32'(exp_count);
`else
    v.cnt = '0;
`endif
    exp_q.push_back(v);
    if (v.done) exp_count++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    #2;
    exp_count = 0;
    push(blank(7));
    clr = 1'b1;
    tick();
    push(blank(7));
  endtask

  task automatic restart(input int idle_cycles);
    repeat (idle_cycles) begin
      tick();
      clr = 1'b0;
      run = 1'b0;
      push(blank(7));
    end
    tick();
    clr = 1'b0;
    run = 1'b1;
    push(blank(7));
  endtask

  // Drives one instruction starting in T0; need_idle reports that the sequencer ends up in IDLE.
  task automatic run_instr(input logic [31:0] iv, input int waits, input bit run_next,
                           input bit abort_t4, output bit need_idle);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int         kind;
    ctl_t       v;
    op = iv[31:27]; ra = iv[26:23]; rb = iv[22:19]; rc = iv[18:15];
    kind = classify(op);
    need_idle = 1'b1;
    $display("instr ir=%h kind=%0d waits=%0d run_next=%0d abort=%0d", iv, kind, waits, run_next, abort_t4);

    tick(); ir = $urandom; mem_rdy = 1'($urandom); run = 1'($urandom);
    v = blank(0); v.pc_out = 1; v.mar_in = 1; v.pcinc_en = 1; v.z_en = 1; push(v);
    for (int w = 0; w < waits; w++) begin
      tick(); mem_rdy = 1'b0; run = 1'($urandom); ir = $urandom;
      v = blank(1); v.zlow_en = 1; v.mdr_read = 1; v.mdr_in = 1; push(v);
    end
    tick(); mem_rdy = 1'b1;
    v = blank(1); v.zlow_en = 1; v.mdr_read = 1; v.mdr_in = 1; v.pc_in = 1; push(v);
    tick(); ir = iv; mem_rdy = 1'($urandom);
    v = blank(2); v.mdr_out = 1; v.ir_in = 1; push(v);

    tick(); mem_rdy = 1'($urandom);
    v = blank(3);
    if (kind == 1) begin v.r_out = hot(rb); v.y_en = 1; end
    else if (kind == 2) begin v.r_out = hot(ra); v.y_en = 1; end
    else if (kind == 3) begin v.r_out = hot(rb); v.opc = op; v.z_en = 1; end
    push(v);

    if (kind == 0) begin
      tick(); v = blank(7); v.illegal = 1; push(v);
      tick(); run = 1'($urandom); push(v);
      clr_pulse();
      return;
    end

    if (kind != 3) begin
      tick();
      v = blank(4); v.r_out = (kind == 2) ? hot(rb) : hot(rc); v.opc = op; v.z_en = 1; push(v);
      if (abort_t4) begin
        clr_pulse();
        return;
      end
    end

    tick();
    v = blank(5); v.zlow_en = 1;
    if (kind == 2) v.lo_in = 1;
    else begin v.r_in = hot(ra); v.done = 1; run = run_next; end
    push(v);

    if (kind == 2) begin
      tick(); run = run_next;
      v = blank(6); v.zhigh_en = 1; v.hi_in = 1; v.done = 1; push(v);
    end
    need_idle = !run_next;
  endtask

  initial begin : stimulus
    logic [4:0]  legal_ops [12];
    logic [31:0] iv;
    logic [4:0]  op;
    bit          ni, rn, ab;
    legal_ops = '{5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01011,
                  5'b01100, 5'b01101, 5'b10001, 5'b10010, 5'b10011, 5'b10100};

    tick();
    push(blank(7));
    restart(1);

    run_instr(32'h28918000, 0, 1'b1, 1'b0, ni);
    run_instr(32'h8AB80000, 0, 1'b1, 1'b0, ni);
    run_instr(32'h98900000, 0, 1'b0, 1'b0, ni);
    restart(2);
    run_instr(32'h28918000, 3, 1'b1, 1'b0, ni);
    run_instr(32'hF8000000, 0, 1'b1, 1'b0, ni);
    restart(1);
    run_instr(32'h28918000, 1, 1'b1, 1'b1, ni);
    restart(0);
    run_instr(32'h28918000, 0, 1'b1, 1'b0, ni);
    run_instr(32'h28918000, 0, 1'b1, 1'b0, ni);
    run_instr(32'h28918000, 0, 1'b0, 1'b0, ni);
    restart(1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) op = 5'($urandom);
      else op = legal_ops[$urandom_range(0, 11)];
      iv = {op, 27'($urandom)};
      rn = 1'($urandom);
      ab = ($urandom_range(0, 9) == 0) && (classify(op) == 1 || classify(op) == 2);
      run_instr(iv, $urandom_range(0, 3), rn, ab, ni);
      if (ni) restart($urandom_range(0, 2));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
